prog_load_ctrl: RTL and testbench
=================================

// Module: prog_load_ctrl
// PURPOSE
//  Sequencer for the single-cycle datapath's external test/load port.
//  Accepts a word stream (header + instruction image + data image), writes it into the instruction and data memories via
//  the ext_instr_* / ext_data_* ports, pulses the core clear, releases flag_HLT to run the program, and watches for halt/timeout.
//  Sits between the host/bench stream and the Datapath_Module memory-access and control pins.
// PARAMETERS
//  IMEM_DEPTH   256   max instruction words accepted (header NI > IMEM_DEPTH -> error)
//  DMEM_DEPTH   256   max data words accepted (header ND > DMEM_DEPTH -> error)
//  CLR_CYCLES   2     cycles core_clr held high in CLEAR (>=1)
//  MAX_RUN      65535 RUN cycles before timeout error; counter width 16
// PORTS
//  clk                input   1   rising-edge clock
//  clr                input   1   asynchronous, active-low reset
//  start              input   1   1-cycle pulse: begin load sequence
//  abort              input   1   return to IDLE from any state
//  ld_valid           input   1   stream word valid
//  ld_data            input   16  stream word
//  ld_ready           output  1   controller can accept word
//  halt_req           input   1   datapath decoded HLT instruction
//  ext_instr_we       output  1   instruction memory write enable
//  ext_instr_addr     output  16  instruction memory write address
//  ext_instr_data     output  16  instruction memory write data
//  ext_data_write_en  output  1   data memory write enable
//  ext_data_addr      output  16  data memory write address
//  ext_data_data      output  16  data memory write data
//  test_normal        output  1   1 = memories driven by ext_* ports, 0 = normal datapath access
//  flag_HLT           output  1   1 = PC frozen
//  core_clr           output  1   datapath clear
//  busy / done / error output 1   status; error_code output 2 (0 none,1 size,2 timeout,3 abort)
//  run_cycles         output  16  cycles spent in last/current RUN
// BEHAVIOUR
//  Reset (clr=0, async): state IDLE; test_normal=1, flag_HLT=1; all we=0, addrs/data=0; core_clr=0; ld_ready=0;
//   busy=done=error=0, error_code=0, run_cycles=0.
//  States: IDLE, HDR_I, HDR_D, LD_I, LD_D, CLEAR, RUN, HALTED, ERROR. Transfer = ld_valid & ld_ready.
//  IDLE/HALTED/ERROR: start -> HDR_I; clears done/error/error_code/run_cycles. start in any other state ignored.
//  HDR_I: ld_ready=1; transfer latches NI=ld_data -> HDR_D. HDR_D: transfer latches ND; if NI>IMEM_DEPTH or
//   ND>DMEM_DEPTH -> ERROR(code 1); else -> LD_I if NI!=0, else LD_D if ND!=0, else CLEAR.
//  LD_I: ld_ready=1; k-th transfer (k from 0) registers ext_instr_addr=k, ext_instr_data=word, ext_instr_we=1 on the
//   next cycle (latency 1, single-cycle pulse per word; ld_valid gaps produce we=0). After NI-th word -> LD_D (ND!=0) or CLEAR.
//  LD_D: same scheme on ext_data_*; address restarts at 0; after ND-th word -> CLEAR.
//  ld_ready=0 in all states except HDR_I, HDR_D, LD_I, LD_D; words offered elsewhere are not consumed.
//  test_normal=1 from reset through LD_D; drops to 0 on entry to CLEAR (last write pulse completes first).
//  CLEAR: core_clr=1 for exactly CLR_CYCLES cycles, flag_HLT=1 -> RUN.
//  RUN: flag_HLT=0; run_cycles increments every cycle; halt_req -> HALTED (flag_HLT=1 next edge, done=1);
//   run_cycles reaches MAX_RUN without halt -> ERROR(code 2), flag_HLT=1. halt_req on the timeout cycle: halt wins.
//  abort: any state -> IDLE next cycle; flag_HLT=1, test_normal=1, we=0, core_clr=0; if aborted from a non-IDLE
//   state, error=1 with code 3 is held until next start. abort and start same cycle: abort wins.
//  busy=1 in HDR_I..RUN. done/error sticky until start. halt_req outside RUN ignored.
// TESTING
//  1 Reset mid-LD_I (clr low after 3 words) -> all outputs at reset values immediately; restart loads from addr 0.
//  2 Stream NI=3, ND=2, words A0..A2,D0..D1, valid continuous -> instr we pulses addr 0,1,2, data we addr 0,1;
//    test_normal falls, core_clr high 2 cycles, flag_HLT falls.
//  3 Stream NI=2, ND=0 with ld_valid toggling 1/0 -> exactly 2 instr writes, no data writes, then CLEAR.
//  4 NI=300 (IMEM_DEPTH=256) -> ERROR, error_code=1, no memory writes.
//  5 RUN, halt_req at run cycle 10 -> done=1, flag_HLT=1, run_cycles=10; MAX_RUN=20 w/o halt -> error_code=2.
//  6 abort+start same cycle during LD_D -> IDLE, error_code=3, start ignored.

Source files
------------

// File: rtl/prog_load_if.sv
// Host/datapath-side bundle of the program-load sequencer: load stream, run control,
// external memory write ports and status.
interface prog_load_if;
   logic        start;
   logic        abort;
   logic        ld_valid;
   logic [15:0] ld_data;
   logic        ld_ready;
   logic        halt_req;
   logic        ext_instr_we;
   logic [15:0] ext_instr_addr;
   logic [15:0] ext_instr_data;
   logic        ext_data_write_en;
   logic [15:0] ext_data_addr;
   logic [15:0] ext_data_data;
   logic        test_normal;
   logic        flag_HLT;
   logic        core_clr;
   logic        busy;
   logic        done;
   logic        error;
   logic [1:0]  error_code;
   logic [15:0] run_cycles;

   modport slave (
      input  start, abort, ld_valid, ld_data, halt_req,
      output ld_ready, ext_instr_we, ext_instr_addr, ext_instr_data,
             ext_data_write_en, ext_data_addr, ext_data_data,
             test_normal, flag_HLT, core_clr, busy, done, error, error_code, run_cycles
   );

   modport master (
      output start, abort, ld_valid, ld_data, halt_req,
      input  ld_ready, ext_instr_we, ext_instr_addr, ext_instr_data,
             ext_data_write_en, ext_data_addr, ext_data_data,
             test_normal, flag_HLT, core_clr, busy, done, error, error_code, run_cycles
   );
endinterface

// File: rtl/prog_load_ctrl.sv
// Load sequencer: header + instruction/data image into the datapath memories, clear the core,
// run it until HLT or timeout.
module prog_load_ctrl #(
   parameter int IMEM_DEPTH = 256,
   parameter int DMEM_DEPTH = 256,
   parameter int CLR_CYCLES = 2,
   parameter int MAX_RUN    = 65535
) (
   input  logic        clk_i,
   input  logic        clr_i,
   prog_load_if.slave  pl
);
   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_HDR_I  = 4'd1;
   localparam logic [3:0] S_HDR_D  = 4'd2;
   localparam logic [3:0] S_LD_I   = 4'd3;
   localparam logic [3:0] S_LD_D   = 4'd4;
   localparam logic [3:0] S_CLEAR  = 4'd5;
   localparam logic [3:0] S_RUN    = 4'd6;
   localparam logic [3:0] S_HALTED = 4'd7;
   localparam logic [3:0] S_ERROR  = 4'd8;

   localparam logic [15:0] IMEM_MAX = 16'(IMEM_DEPTH);
   localparam logic [15:0] DMEM_MAX = 16'(DMEM_DEPTH);
   localparam logic [15:0] RUN_MAX  = 16'(MAX_RUN);
   localparam logic [7:0]  CLR_LAST = 8'(CLR_CYCLES - 1);

   logic [3:0]  state_q, state_d;
   logic [15:0] ni_q, ni_d, nd_q, nd_d, cnt_q, cnt_d;
   logic        iwe_q, iwe_d, dwe_q, dwe_d;
   logic [15:0] iaddr_q, iaddr_d, idata_q, idata_d;
   logic [15:0] daddr_q, daddr_d, ddata_q, ddata_d;
   logic        tn_q, tn_d, hlt_q, hlt_d, cclr_q, cclr_d;
   logic [7:0]  ccnt_q, ccnt_d;
   logic        done_q, done_d, err_q, err_d;
   logic [1:0]  code_q, code_d;
   logic [15:0] rc_q, rc_d;
   logic        ld_ready, xfer, go_clear;

   assign ld_ready = (state_q == S_HDR_I) || (state_q == S_HDR_D) ||
                     (state_q == S_LD_I)  || (state_q == S_LD_D);
   assign xfer     = pl.ld_valid & ld_ready;

   always_comb begin
      state_d = state_q;  ni_d = ni_q;  nd_d = nd_q;  cnt_d = cnt_q;
      iwe_d = 1'b0;  iaddr_d = iaddr_q;  idata_d = idata_q;
      dwe_d = 1'b0;  daddr_d = daddr_q;  ddata_d = ddata_q;
      tn_d = tn_q;  hlt_d = hlt_q;  cclr_d = cclr_q;  ccnt_d = ccnt_q;
      done_d = done_q;  err_d = err_q;  code_d = code_q;  rc_d = rc_q;
      go_clear = 1'b0;
      if (pl.abort) begin
         state_d = S_IDLE;  hlt_d = 1'b1;  tn_d = 1'b1;  cclr_d = 1'b0;
         if (state_q != S_IDLE) begin
            err_d  = 1'b1;
            code_d = 2'd3;
         end
      end else begin
         case (state_q)
            S_IDLE, S_HALTED, S_ERROR: if (pl.start) begin
               state_d = S_HDR_I;  done_d = 1'b0;  err_d = 1'b0;  code_d = 2'd0;
               rc_d = '0;  tn_d = 1'b1;  hlt_d = 1'b1;
            end
            S_HDR_I: if (xfer) begin
               ni_d    = pl.ld_data;
               state_d = S_HDR_D;
            end
            S_HDR_D: if (xfer) begin
               nd_d  = pl.ld_data;
               cnt_d = '0;
               if (ni_q > IMEM_MAX || pl.ld_data > DMEM_MAX) begin
                  state_d = S_ERROR;  err_d = 1'b1;  code_d = 2'd1;
               end else if (ni_q != '0)       state_d = S_LD_I;
               else if (pl.ld_data != '0)     state_d = S_LD_D;
               else                           go_clear = 1'b1;
            end
            S_LD_I: if (xfer) begin
               iwe_d = 1'b1;  iaddr_d = cnt_q;  idata_d = pl.ld_data;  cnt_d = cnt_q + 16'd1;
               if (cnt_q == ni_q - 16'd1) begin
                  cnt_d = '0;
                  if (nd_q != '0) state_d = S_LD_D;
                  else            go_clear = 1'b1;
               end
            end
            S_LD_D: if (xfer) begin
               dwe_d = 1'b1;  daddr_d = cnt_q;  ddata_d = pl.ld_data;  cnt_d = cnt_q + 16'd1;
               if (cnt_q == nd_q - 16'd1) go_clear = 1'b1;
            end
            S_CLEAR: begin
               // drop test_normal one cycle late so the final image write lands via ext_*
               tn_d = 1'b0;
               if (ccnt_q == CLR_LAST) begin
                  state_d = S_RUN;  cclr_d = 1'b0;  hlt_d = 1'b0;
               end else begin
                  ccnt_d = ccnt_q + 8'd1;
               end
            end
            S_RUN: begin
               rc_d = rc_q + 16'd1;
               if (pl.halt_req) begin
                  state_d = S_HALTED;  hlt_d = 1'b1;  done_d = 1'b1;
               end else if (rc_q + 16'd1 == RUN_MAX) begin
                  state_d = S_ERROR;  hlt_d = 1'b1;  err_d = 1'b1;  code_d = 2'd2;
               end
            end
            default: state_d = S_IDLE;
         endcase
         if (go_clear) begin
            state_d = S_CLEAR;  cclr_d = 1'b1;  ccnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge clr_i) begin
      if (!clr_i) begin
         state_q <= S_IDLE;  ni_q <= '0;  nd_q <= '0;  cnt_q <= '0;
         iwe_q <= 1'b0;  iaddr_q <= '0;  idata_q <= '0;
         dwe_q <= 1'b0;  daddr_q <= '0;  ddata_q <= '0;
         tn_q <= 1'b1;  hlt_q <= 1'b1;  cclr_q <= 1'b0;  ccnt_q <= '0;
         done_q <= 1'b0;  err_q <= 1'b0;  code_q <= 2'd0;  rc_q <= '0;
      end else begin
         state_q <= state_d;  ni_q <= ni_d;  nd_q <= nd_d;  cnt_q <= cnt_d;
         iwe_q <= iwe_d;  iaddr_q <= iaddr_d;  idata_q <= idata_d;
         dwe_q <= dwe_d;  daddr_q <= daddr_d;  ddata_q <= ddata_d;
         tn_q <= tn_d;  hlt_q <= hlt_d;  cclr_q <= cclr_d;  ccnt_q <= ccnt_d;
         done_q <= done_d;  err_q <= err_d;  code_q <= code_d;  rc_q <= rc_d;
      end
   end

   assign pl.ld_ready          = ld_ready;
   assign pl.ext_instr_we      = iwe_q;
   assign pl.ext_instr_addr    = iaddr_q;
   assign pl.ext_instr_data    = idata_q;
   assign pl.ext_data_write_en = dwe_q;
   assign pl.ext_data_addr     = daddr_q;
   assign pl.ext_data_data     = ddata_q;
   assign pl.test_normal       = tn_q;
   assign pl.flag_HLT          = hlt_q;
   assign pl.core_clr          = cclr_q;
   assign pl.busy              = (state_q >= S_HDR_I) && (state_q <= S_RUN);
   assign pl.done              = done_q;
   assign pl.error             = err_q;
   assign pl.error_code        = code_q;
   assign pl.run_cycles        = rc_q;
endmodule

// File: tb/tb_prog_load_ctrl.sv
// Randomized stream bench for prog_load_ctrl against an image-level write/run model.
module tb_prog_load_ctrl;
   localparam int IMEM = 256, DMEM = 256, CLR_CYCLES = 2, MAX_RUN = 20;

   logic clk = 1'b0, clr_n = 1'b0;
   always #5 clk = ~clk;

   prog_load_if pl();
   prog_load_ctrl #(.IMEM_DEPTH(IMEM), .DMEM_DEPTH(DMEM), .CLR_CYCLES(CLR_CYCLES), .MAX_RUN(MAX_RUN))
      dut (.clk_i(clk), .clr_i(clr_n), .pl(pl));

   int errs = 0, checks = 0;
   logic [15:0] stream[$];
   logic [31:0] exp_i[$], exp_d[$], obs_i[$], obs_d[$];
   int clr_hi = 0, tn_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) if (clr_n) begin
      if (pl.ext_instr_we) begin
         obs_i.push_back({pl.ext_instr_addr, pl.ext_instr_data});
         if (!pl.test_normal) tn_bad++;
      end
      if (pl.ext_data_write_en) begin
         obs_d.push_back({pl.ext_data_addr, pl.ext_data_data});
         if (!pl.test_normal) tn_bad++;
      end
      if (pl.core_clr) clr_hi++;
   end

   // image model: header then words; k-th word of each image goes to address k
   task automatic build(input int ni, input int nd);
      logic [15:0] w;
      stream = {}; exp_i = {}; exp_d = {};
      stream.push_back(16'(ni));
      stream.push_back(16'(nd));
      if (ni > IMEM || nd > DMEM) return;
      for (int k = 0; k < ni; k++) begin
         w = 16'($urandom); stream.push_back(w); exp_i.push_back({16'(k), w});
      end
      for (int k = 0; k < nd; k++) begin
         w = 16'($urandom); stream.push_back(w); exp_d.push_back({16'(k), w});
      end
   endtask

   // mode 0: continuous valid, 1: alternating, 2: random gaps
   task automatic send(input int n, input int mode);
      int idx = 0, budget = 0;
      bit ph = 1'b0;
      while (idx < n && budget < 3000) begin
         @(negedge clk);
         ph = ~ph;
         pl.ld_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ph : 1'($urandom_range(0, 1));
         pl.ld_data  = stream[idx];
         if (pl.ld_valid && pl.ld_ready) idx++;
         budget++;
      end
      if (idx < n) chk("stream_timeout", idx, n);
   endtask

   task automatic start_pulse();
      @(negedge clk) pl.start = 1'b1;
      @(negedge clk) pl.start = 1'b0;
   endtask

   task automatic run_case(input int ni, input int nd, input int mode, input int halt_at);
      bit err;
      int w;
      err = (ni > IMEM) || (nd > DMEM);
      build(ni, nd);
      start_pulse();
      obs_i = {}; obs_d = {}; clr_hi = 0; tn_bad = 0;
      chk("busy_after_start", pl.busy, 1);
      chk("status_cleared", {pl.done, pl.error, pl.error_code}, 0);
      send(err ? 2 : 2 + ni + nd, mode);
      @(negedge clk) pl.ld_valid = 1'b0;
      if (err) begin
         repeat (2) @(negedge clk);
         chk("size_err", {pl.error, pl.error_code}, {1'b1, 2'd1});
         chk("size_err_nowr", obs_i.size() + obs_d.size(), 0);
         chk("size_err_idle", {pl.busy, pl.flag_HLT, pl.ld_ready}, 3'b010);
         return;
      end
      w = 0;
      while (pl.flag_HLT && w < 50) begin @(negedge clk); w++; end
      chk("run_entry", pl.flag_HLT, 0);
      chk("instr_count", obs_i.size(), exp_i.size());
      for (int k = 0; k < exp_i.size() && k < obs_i.size(); k++) chk("instr_wr", obs_i[k], exp_i[k]);
      chk("data_count", obs_d.size(), exp_d.size());
      for (int k = 0; k < exp_d.size() && k < obs_d.size(); k++) chk("data_wr", obs_d[k], exp_d[k]);
      chk("clr_cycles", clr_hi, CLR_CYCLES);
      chk("tn_at_write", tn_bad, 0);
      chk("run_state", {pl.test_normal, pl.core_clr, pl.ld_ready, pl.busy}, 4'b0001);
      chk("rc_start", pl.run_cycles, 0);
      if (halt_at > 0) begin
         for (int c = 1; c < halt_at; c++) @(negedge clk);
         pl.halt_req = 1'b1;
         @(negedge clk) pl.halt_req = 1'b0;
         chk("halt_status", {pl.done, pl.error, pl.flag_HLT, pl.busy}, 4'b1010);
         chk("halt_rc", pl.run_cycles, halt_at);
      end else begin
         w = 0;
         while (!pl.error && w < MAX_RUN + 10) begin @(negedge clk); w++; end
         chk("timeout_code", {pl.error, pl.error_code, pl.done}, {1'b1, 2'd2, 1'b0});
         chk("timeout_rc", pl.run_cycles, MAX_RUN);
         chk("timeout_hlt", pl.flag_HLT, 1);
      end
   endtask

   initial begin
      pl.start = 0; pl.abort = 0; pl.ld_valid = 0; pl.ld_data = '0; pl.halt_req = 0;
      #12;
      chk("rst_out", {pl.ext_instr_we, pl.ext_data_write_en, pl.test_normal, pl.flag_HLT,
                      pl.core_clr, pl.ld_ready, pl.busy, pl.done, pl.error}, 9'b001100000);
      chk("rst_vals", {pl.ext_instr_addr, pl.ext_data_data, pl.run_cycles, 14'd0, pl.error_code}, 0);
      @(negedge clk) clr_n = 1'b1;

      // async reset in the middle of the instruction image
      build(5, 1);
      start_pulse();
      send(5, 0);
      @(posedge clk);
      #2 clr_n = 1'b0;
      #1;
      chk("midrst_out", {pl.ext_instr_we, pl.test_normal, pl.flag_HLT, pl.ld_ready, pl.busy,
                         pl.core_clr}, 6'b011000);
      chk("midrst_addr", {pl.ext_instr_addr, pl.ext_instr_data}, 0);
      pl.ld_valid = 1'b0;
      @(negedge clk) clr_n = 1'b1;

      run_case(4, 3, 0, 7);
      run_case(3, 2, 0, 10);
      run_case(2, 0, 1, 0);
      run_case(300, 1, 0, 0);
      run_case(1, 257, 0, 0);
      run_case(0, 0, 0, 5);
      run_case(0, 2, 2, 3);
      run_case(256, 1, 0, MAX_RUN);

      // abort with a simultaneous start during the data image
      build(3, 4);
      start_pulse();
      obs_d = {};
      send(6, 0);
      @(negedge clk);
      pl.ld_valid = 1'b0; pl.abort = 1'b1; pl.start = 1'b1;
      @(negedge clk);
      pl.abort = 1'b0; pl.start = 1'b0;
      chk("abort_err", {pl.error, pl.error_code}, {1'b1, 2'd3});
      chk("abort_out", {pl.busy, pl.flag_HLT, pl.test_normal, pl.ld_ready, pl.ext_data_write_en}, 5'b01100);
      repeat (2) @(negedge clk);
      chk("abort_start_ignored", pl.busy, 0);
      chk("abort_data_wr", obs_d.size(), 1);

      for (int r = 0; r < 6; r++)
         run_case($urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 2), $urandom_range(0, MAX_RUN));

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errs);
      $fatal(1);
   end
endmodule
